// File: rtl/mdu_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam int MDU_MULT_LAT_DEF = 5;
  localparam int MDU_DIV_LAT_DEF  = 10;

  typedef enum logic {MDU_IDLE, MDU_BUSY} mdu_state_e;

endpackage

// File: rtl/md_unit_if.sv
// Decoder/hazard-side bundle of the multiply/divide unit: strobes, operands, HI/LO read-back.
interface md_unit_if;

  logic        start;
  logic [1:0]  mdu_sel;
  logic        hi_en;
  logic        lo_en;
  logic        out_sel;
  logic        kill;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] out;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, mdu_sel, hi_en, lo_en, out_sel, kill, a, b,
    input  busy, out, hi, lo
  );

  modport slave (
    input  start, mdu_sel, hi_en, lo_en, out_sel, kill, a, b,
    output busy, out, hi, lo
  );

endinterface

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: computes the 64-bit result at launch, then holds it
// for a fixed latency before committing to HI/LO.
module md_unit
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MDU_MULT_LAT_DEF,
  parameter int DIV_LAT  = MDU_DIV_LAT_DEF
) (
  input  logic    clk,
  input  logic    reset,
  md_unit_if.slave bus
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  mdu_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       hi_q, lo_q;
  logic [31:0]       res_hi_q, res_lo_q;
  logic [63:0]       res_d;
  logic signed [63:0] sa, sb;

  // 64-bit signed operands keep 0x80000000 / -1 from overflowing the quotient.
  assign sa = {{32{bus.a[31]}}, bus.a};
  assign sb = {{32{bus.b[31]}}, bus.b};

  // On divide by zero the current HI/LO are captured, so the commit is a no-op;
  // HI/LO cannot change while BUSY.
  always_comb begin
    res_d = {hi_q, lo_q};
    case (bus.mdu_sel)
      MDU_MULT:  res_d = sa * sb;
      MDU_MULTU: res_d = {32'b0, bus.a} * {32'b0, bus.b};
      MDU_DIV:   if (bus.b != 32'b0) res_d = {32'(sa % sb), 32'(sa / sb)};
      MDU_DIVU:  if (bus.b != 32'b0) res_d = {bus.a % bus.b, bus.a / bus.b};
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (bus.start && !bus.kill) begin
            res_hi_q <= res_d[63:32];
            res_lo_q <= res_d[31:0];
            cnt_q    <= bus.mdu_sel[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            state_q  <= MDU_BUSY;
          end else begin
            if (bus.hi_en && !bus.kill) hi_q <= bus.a;
            if (bus.lo_en && !bus.kill) lo_q <= bus.a;
          end
        end
        MDU_BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            hi_q    <= res_hi_q;
            lo_q    <= res_lo_q;
            state_q <= MDU_IDLE;
          end
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q == MDU_BUSY);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.out  = bus.out_sel ? lo_q : hi_q;

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit in the E stage of the pipelined MIPS core. It executes mult, multu, div and divu over a fixed number of cycles and owns the HI/LO registers. It serves mthi, mtlo, mfhi and mflo. It receives the start, select, write-enable and read-select strobes that the instruction decoder produces, and it returns `busy` to the hazard unit, which stalls any HI/LO-class instruction in D.

## Interface
Parameters:
- `MULT_LAT`, default 5: cycles from a mult/multu start to HI/LO commit.
- `DIV_LAT`, default 10: cycles from a div/divu start to HI/LO commit.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `start` in 1: launch an operation selected by `mdu_sel`.
- `mdu_sel` in 2: operation select; 00 mult, 01 multu, 10 div, 11 divu.
- `hi_en` in 1: mthi; write `a` to HI.
- `lo_en` in 1: mtlo; write `a` to LO.
- `out_sel` in 1: read select; 0 gives HI (mfhi), 1 gives LO (mflo).
- `kill` in 1: E-stage instruction is being flushed (exception/interrupt taken in M); suppresses `start`, `hi_en` and `lo_en` this cycle.
- `a` in 32: rs operand (forwarded).
- `b` in 32: rt operand (forwarded).
- `busy` out 1: an operation is in flight.
- `out` out 32: selected HI/LO value.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
State machine with two states.

IDLE:
- A rising edge with `start & ~kill` does the following:
  - latches the full 64-bit result of `a` op `b` into internal `res_hi`/`res_lo`;
  - loads `cnt` with `MULT_LAT` (mdu_sel[1]=0) or `DIV_LAT` (mdu_sel[1]=1);
  - moves to BUSY.
- Otherwise `hi_en & ~kill` writes `a` to HI, and `lo_en & ~kill` writes `a` to LO.
- `start` has priority over `hi_en`/`lo_en` if they are asserted together.

BUSY:
- `cnt` decrements on each edge.
- On the edge where `cnt`==1, `res_hi` is written to HI and `res_lo` to LO, `cnt` becomes 0, and the state returns to IDLE.
- `start`, `hi_en` and `lo_en` are ignored in BUSY. The hazard unit guarantees they do not occur, but an occurrence must not corrupt the operation.
- `kill` has no effect on an operation already in BUSY. An operation that has started always commits.

Arithmetic:
- mult: signed 32x32 to 64; HI = product[63:32], LO = product[31:0].
- multu: the same, unsigned.
- div: signed, truncating toward zero; LO = quotient, HI = remainder, and the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned; LO = quotient, HI = remainder.
- Divide by zero (b==0 on div/divu): the operation still occupies `DIV_LAT` cycles, and HI and LO are left unchanged at commit.

Outputs:
- `busy` = (state==BUSY).
- `out` = `out_sel` ? LO : HI, combinational from the registers.

## Timing
- Reset values: state IDLE, `cnt`=0, `busy`=0, HI=0, LO=0, `res_hi`=`res_lo`=0, `out`=0.
- Reset asserted mid-operation aborts the operation, leaves HI and LO at 0, and drops `busy` asynchronously.
- Start sampled at edge k:
  - `busy` is 1 after edge k through edge k+N−1, and 0 after edge k+N, where N=`MULT_LAT` or `DIV_LAT`.
  - New HI/LO are visible on `hi`/`lo`/`out` after edge k+N.
- In the start cycle itself `busy` is still 0. The hazard unit stalls on `start | busy`.
- mthi/mtlo write at the sampling edge; `out` reflects the new value in the next cycle.
- `out` does not bypass HI/LO values that are pending in `res_hi`/`res_lo`.

## Structure
- Shared package `mdu_pkg` holds:
  - the `mdu_sel` encodings `MDU_MULT`=2'b00, `MDU_MULTU`=2'b01, `MDU_DIV`=2'b10, `MDU_DIVU`=2'b11;
  - the state encoding `MDU_IDLE`, `MDU_BUSY`;
  - the default latencies 5 and 10.
- The block is a single module with no sub-module. Result computation is one combinational case on `mdu_sel` feeding the `res_*` registers.
- `cnt` is sized for `DIV_LAT` (4 bits at default).

## Test plan
- Mult, signed: a=0xFFFFFFFF, b=2, mult → `busy` 1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Repeat with multu → HI=0x00000001, LO=0xFFFFFFFE.
- Div, signed: a=0xFFFFFFF9 (−7), b=2, div → `busy` 1 for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Repeat with divu a=7, b=2 → LO=3, HI=1.
- Divide by zero: HI=0x11, LO=0x22 preset via mthi/mtlo; div b=0 → 10 busy cycles; HI=0x11, LO=0x22 after commit. Also 0x80000000 div 0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi/mtlo/mfhi/mflo: mthi a=0xDEADBEEF, then mtlo a=0x12345678 → `out`=0xDEADBEEF with `out_sel`=0, 0x12345678 with `out_sel`=1. `start` with `hi_en` in the same cycle → the multiply wins and HI is not written by mthi.
- Kill and busy: `start` with `kill`=1 → `busy` stays 0 and HI/LO are unchanged. `start`/`hi_en` pulses during BUSY → ignored; the original result commits on schedule.
- Reset mid-operation: reset asserted at cycle 3 of a div → `busy`=0, HI=LO=0 immediately. After release, a fresh mult completes normally in 5 cycles.
